light_timer: RTL and testbench



---
 rtl/light_pkg.sv | 20 ++
 rtl/light_timer_sec_prescaler.sv | 28 ++
 rtl/light_timer.sv | 87 ++++++++
 tb/tb_light_timer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light FSM and its timing back-end.
package light_pkg;

    localparam int LIGHT_STATE_WIDTH = 3;

    localparam int pGREEN_IDX  = 0;
    localparam int pYELLOW_IDX = 1;
    localparam int pRED_IDX    = 2;

    localparam int pGREEN_SEC  = 30;
    localparam int pYELLOW_SEC = 3;
    localparam int pRED_SEC    = 25;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/light_timer_sec_prescaler.sv
// Clock-to-second prescaler: free-running modulo-CLK_PER_SEC counter while advancing.
module sec_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic advance,
    output logic wrap,
    output logic pre_last
);

    localparam int SEC_W = $clog2(CLK_PER_SEC);

    logic [SEC_W-1:0] sec_cnt;

    // Idle value is the last count so the first advancing edge wraps.
    always_ff @(posedge clk) begin
        if (rst || !en)
            sec_cnt <= SEC_W'(CLK_PER_SEC - 1);
        else if (advance)
            sec_cnt <= wrap ? '0 : sec_cnt + 1'b1;
    end

    assign wrap     = advance && (sec_cnt == SEC_W'(CLK_PER_SEC - 1));
    assign pre_last = (sec_cnt == SEC_W'(CLK_PER_SEC - 2));

endmodule

// File: rtl/light_timer.sv
// Timing back-end for the traffic-light FSM: second strobes and per-light countdown.
module light_timer #(
    parameter int LIGHT_STATE_WIDTH = light_pkg::LIGHT_STATE_WIDTH,
    parameter int CLK_PER_SEC       = 50_000_000,
    parameter int GREEN_SEC         = light_pkg::pGREEN_SEC,
    parameter int YELLOW_SEC        = light_pkg::pYELLOW_SEC,
    parameter int RED_SEC           = light_pkg::pRED_SEC,
    localparam int CNT_W = $clog2(light_pkg::max3(GREEN_SEC, YELLOW_SEC, RED_SEC) + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
    output logic                         second_cnt_pre_last,
    output logic                         light_cnt_last,
    output logic [CNT_W-1:0]             sec_left,
    output logic                         init_err
);

    import light_pkg::*;

    if (CLK_PER_SEC < 2) begin : g_chk_clk
        $error("light_timer: CLK_PER_SEC must be >= 2");
    end
    if (GREEN_SEC < 1 || YELLOW_SEC < 1 || RED_SEC < 1) begin : g_chk_dur
        $error("light_timer: light durations must be >= 1");
    end
    if (LIGHT_STATE_WIDTH <= pRED_IDX) begin : g_chk_width
        $error("light_timer: LIGHT_STATE_WIDTH too small");
    end

    logic             en_d;
    logic             advance;
    logic             wrap;
    logic             pre_last;
    logic             multi_hot;
    logic [CNT_W-1:0] light_cnt;
    logic [CNT_W-1:0] load_val;

    assign advance = en && en_d;

    sec_prescaler #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .advance (advance),
        .wrap    (wrap),
        .pre_last(pre_last)
    );

    // Loads are duration-1 because the init pulse lands on the wrap edge.
    always_comb begin
        load_val = CNT_W'(GREEN_SEC - 1);
        if (light_cnt_init[pRED_IDX])
            load_val = CNT_W'(RED_SEC - 1);
        else if (light_cnt_init[pYELLOW_IDX])
            load_val = CNT_W'(YELLOW_SEC - 1);
    end

    assign multi_hot = (light_cnt_init & (light_cnt_init - 1'b1)) != '0;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            en_d      <= 1'b0;
            light_cnt <= CNT_W'(GREEN_SEC);
            init_err  <= 1'b0;
        end else begin
            en_d     <= 1'b1;
            init_err <= 1'b0;
            if (en_d) begin
                if (light_cnt_init != '0) begin
                    light_cnt <= load_val;
                    init_err  <= multi_hot;
                end else if (wrap && light_cnt != '0) begin
                    light_cnt <= light_cnt - 1'b1;
                end
            end
        end
    end

    assign second_cnt_pre_last = en_d && pre_last;
    assign light_cnt_last      = en_d && (light_cnt == '0);
    assign sec_left            = light_cnt;

endmodule

// File: tb/tb_light_timer.sv
// Bench for light_timer paired with a small traffic-light FSM model.
module tb_light_timer;

    localparam int CPS = 4;
    localparam int GS  = 3;
    localparam int YS  = 1;
    localparam int RS  = 2;

    typedef struct {
        logic [1:0] sec_left;
        logic       pre;
        logic       last;
        logic       err;
        logic [2:0] init;
    } vec_t;

    typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_RED} st_t;

    logic       clk, rst, en, ovr;
    logic [2:0] ovr_val, fsm_init, light_cnt_init;
    logic       second_cnt_pre_last, light_cnt_last, init_err;
    logic [1:0] sec_left;
    st_t        st;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl [0:36];
    vec_t sb  [$];

    assign light_cnt_init = ovr ? ovr_val : fsm_init;

    light_timer #(
        .LIGHT_STATE_WIDTH(3),
        .CLK_PER_SEC(CPS),
        .GREEN_SEC(GS),
        .YELLOW_SEC(YS),
        .RED_SEC(RS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .light_cnt_init     (light_cnt_init),
        .second_cnt_pre_last(second_cnt_pre_last),
        .light_cnt_last     (light_cnt_last),
        .sec_left           (sec_left),
        .init_err           (init_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FSM partner: moves on last & pre_last and pulses the new light's init.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            st       <= S_IDLE;
            fsm_init <= 3'b000;
        end else begin
            fsm_init <= 3'b000;
            case (st)
                S_IDLE:   st <= S_GREEN;
                S_GREEN:  if (light_cnt_last && second_cnt_pre_last) begin st <= S_YELLOW; fsm_init <= 3'b010; end
                S_YELLOW: if (light_cnt_last && second_cnt_pre_last) begin st <= S_RED;    fsm_init <= 3'b100; end
                default:  if (light_cnt_last && second_cnt_pre_last) begin st <= S_GREEN;  fsm_init <= 3'b001; end
            endcase
        end
    end

    function automatic vec_t mk(input int s, input bit p, input bit l, input bit e, input logic [2:0] i);
        vec_t v;
        v.sec_left = 2'(s); v.pre = p; v.last = l; v.err = e; v.init = i;
        return v;
    endfunction

    // Expected startup/full-cycle trace, cycle 0 = first cycle with en = 1.
    function automatic vec_t golden(input int c);
        int         s;
        bit         p, l;
        logic [2:0] i;
        if      (c <= 1)  s = 3;
        else if (c <= 5)  s = 2;
        else if (c <= 9)  s = 1;
        else if (c <= 17) s = 0;
        else if (c <= 21) s = 1;
        else if (c <= 25) s = 0;
        else if (c <= 29) s = 2;
        else if (c <= 33) s = 1;
        else              s = 0;
        p = (c >= 4) && (c % 4 == 0);
        l = (c >= 10 && c <= 17) || (c >= 22 && c <= 25) || (c >= 34);
        i = (c == 13) ? 3'b010 : (c == 17) ? 3'b100 : (c == 25) ? 3'b001 : 3'b000;
        return mk(s, p, l, 1'b0, i);
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic o, input logic [2:0] ov,
                        input vec_t ex, input bit ci, input string tag);
        vec_t got;
        @(posedge clk);
        #1;
        rst = r; en = e; ovr = o; ovr_val = ov;
        sb.push_back(ex);
        @(negedge clk);
        got = sb.pop_front();
        chk({tag, ".sec_left"}, int'(sec_left), int'(got.sec_left));
        chk({tag, ".pre_last"}, int'(second_cnt_pre_last), int'(got.pre));
        chk({tag, ".last"},     int'(light_cnt_last), int'(got.last));
        chk({tag, ".init_err"}, int'(init_err), int'(got.err));
        if (ci) chk({tag, ".init"}, int'(light_cnt_init), int'(got.init));
    endtask

    initial begin
        vec_t idle;
        idle = mk(GS, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int c = 0; c <= 36; c++) tbl[c] = golden(c);

        rst = 1'b1; en = 1'b0; ovr = 1'b0; ovr_val = 3'b000;
        repeat (2) @(posedge clk);

        step(1, 0, 0, 3'b000, idle, 1, "reset0");
        step(1, 0, 0, 3'b000, idle, 1, "reset1");

        // Init request while disabled must not load or flag.
        for (int k = 0; k < 3; k++) step(0, 0, 1, 3'b010, idle, 0, $sformatf("idle_init%0d", k));

        for (int c = 0; c <= 36; c++) step(0, 1, 0, 3'b000, tbl[c], 1, $sformatf("run_c%0d", c));

        // Reset mid-count (cycle 37 = first yellow cycle), then a fresh start.
        step(1, 1, 0, 3'b000, mk(0, 1'b0, 1'b1, 1'b0, 3'b010), 1, "rst_c37");
        for (int c = 0; c <= 6; c++) step(0, 1, 0, 3'b000, tbl[c], 1, $sformatf("after_rst_c%0d", c));

        // Enable drop at cycle 7, idle at 8, then a full green again.
        step(0, 0, 0, 3'b000, tbl[7], 1, "endrop_c7");
        step(0, 0, 0, 3'b000, idle, 1, "endrop_c8");
        for (int c = 0; c <= 13; c++) step(0, 1, 0, 3'b000, tbl[c], 1, $sformatf("reen_c%0d", c));
        step(0, 0, 0, 3'b000, tbl[14], 1, "drop2_c14");
        step(0, 0, 0, 3'b000, idle, 1, "drop2_idle");

        // Multi-hot init at sec_cnt = CPS-1 (cycle 9): red wins, one-cycle error.
        for (int c = 0; c <= 8; c++) step(0, 1, 0, 3'b000, tbl[c], 1, $sformatf("mh_c%0d", c));
        step(0, 1, 1, 3'b110, mk(1, 1'b0, 1'b0, 1'b0, 3'b110), 1, "mh_c9");
        step(0, 1, 0, 3'b000, mk(RS - 1, 1'b0, 1'b0, 1'b1, 3'b000), 1, "mh_c10");
        step(0, 1, 0, 3'b000, mk(RS - 1, 1'b0, 1'b0, 1'b0, 3'b000), 1, "mh_c11");
        step(0, 1, 0, 3'b000, mk(RS - 1, 1'b1, 1'b0, 1'b0, 3'b000), 1, "mh_c12");
        step(0, 1, 0, 3'b000, mk(RS - 1, 1'b0, 1'b0, 1'b0, 3'b000), 1, "mh_c13");
        step(0, 1, 0, 3'b000, mk(0, 1'b0, 1'b1, 1'b0, 3'b000), 1, "mh_c14");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
